spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_spi_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master between two word requesters.
// Each requester owns a one-deep holding register. A small FSM grants the
// pending words round-robin, strobes the SPI master, waits for its busy flag
// to rise and fall, and reports completion (or a start timeout) per requester.
module spi_arbiter #(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_start,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_busy,
   output logic              req0_done,
   input  logic              req1_start,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_busy,
   output logic              req1_done,
   output logic              spi_start,
   output logic [DATA_W-1:0] spi_data,
   input  logic              spi_busy,
   output logic [1:0]        overrun,
   output logic              timeout
);

   // One extra bit so the counter can never wrap before reaching TIMEOUT-1.
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWaitBusy,
      StWaitDone
   } state_t;

   state_t            state;
   logic              grant;       // requester currently owning the SPI master
   logic              last_grant;  // requester served most recently
   logic [CNT_W-1:0]  cnt;

   logic              pend0;
   logic              pend1;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic              ovr0;
   logic              ovr1;

   logic              finish;      // transfer ends this cycle (normal or aborted)
   logic              expire;      // busy never rose within the allowed window
   logic              pick;        // requester to grant from IDLE

   assign req0_busy = pend0;
   assign req1_busy = pend1;
   assign overrun   = {ovr1, ovr0};

   // Transfer-end detection and round-robin choice between pending words.
   always_comb begin
      finish = 1'b0;
      expire = 1'b0;
      if (state == StWaitDone && !spi_busy) begin
         finish = 1'b1;
      end
      if (state == StWaitBusy && !spi_busy && cnt == CNT_LAST) begin
         finish = 1'b1;
         expire = 1'b1;
      end
      if (pend0 && pend1) begin
         pick = ~last_grant;
      end else begin
         pick = pend1 & ~pend0;
      end
   end

   // Requester 0 holding register. A request while the word is pending, or in
   // the cycle its done pulse is visible, is dropped and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend0 <= 1'b0;
         data0 <= '0;
         ovr0  <= 1'b0;
      end else begin
         ovr0 <= 1'b0;
         // Clear only happens while pend0 is set, so it never collides with a capture.
         if (finish && !grant) begin
            pend0 <= 1'b0;
         end
         if (req0_start) begin
            if (pend0 || req0_done) begin
               ovr0 <= 1'b1;
            end else begin
               pend0 <= 1'b1;
               data0 <= req0_data;
            end
         end
      end
   end

   // Requester 1 holding register, same rules as requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend1 <= 1'b0;
         data1 <= '0;
         ovr1  <= 1'b0;
      end else begin
         ovr1 <= 1'b0;
         if (finish && grant) begin
            pend1 <= 1'b0;
         end
         if (req1_start) begin
            if (pend1 || req1_done) begin
               ovr1 <= 1'b1;
            end else begin
               pend1 <= 1'b1;
               data1 <= req1_data;
            end
         end
      end
   end

   // Arbitration FSM with registered strobes towards the SPI master and requesters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         spi_start  <= 1'b0;
         spi_data   <= '0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         spi_start <= 1'b0;
         req0_done <= 1'b0;
         req1_done <= 1'b0;
         timeout   <= 1'b0;
         case (state)
            StIdle: begin
               if (pend0 || pend1) begin
                  grant     <= pick;
                  spi_data  <= pick ? data1 : data0;
                  spi_start <= 1'b1;
                  state     <= StStart;
               end
            end
            StStart: begin
               cnt   <= '0;
               state <= StWaitBusy;
            end
            StWaitBusy: begin
               if (spi_busy) begin
                  state <= StWaitDone;
               end else if (expire) begin
                  timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StWaitDone: begin
               // Wait indefinitely; the master has acknowledged the word.
            end
            default: begin
               state <= StIdle;
            end
         endcase
         // Common completion path for normal end and timeout abort.
         if (finish) begin
            req0_done  <= ~grant;
            req1_done  <= grant;
            last_grant <= grant;
            state      <= StIdle;
         end
      end
   end

   // Only one requester can finish per cycle, and the start strobe lives only in START.
   a_done_onehot : assert property (@(posedge clk) disable iff (rst)
      !(req0_done && req1_done));
   a_start_in_start : assert property (@(posedge clk) disable iff (rst)
      spi_start |-> state == StStart);

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: table-driven check of one arbitrated exchange, followed by
// hand-written sequences for alternation, timeout abort and mid-transfer reset.
module tb_spi_arbiter;

   localparam int unsigned DATA_W  = 24;
   localparam int unsigned TIMEOUT = 16;

   logic              clk;
   logic              rst;
   logic              req0_start;
   logic [DATA_W-1:0] req0_data;
   logic              req0_busy;
   logic              req0_done;
   logic              req1_start;
   logic [DATA_W-1:0] req1_data;
   logic              req1_busy;
   logic              req1_done;
   logic              spi_start;
   logic [DATA_W-1:0] spi_data;
   logic              spi_busy;
   logic [1:0]        overrun;
   logic              timeout;

   int total = 0;
   int bad   = 0;

   spi_arbiter #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_start (req0_start),
      .req0_data  (req0_data),
      .req0_busy  (req0_busy),
      .req0_done  (req0_done),
      .req1_start (req1_start),
      .req1_data  (req1_data),
      .req1_busy  (req1_busy),
      .req1_done  (req1_done),
      .spi_start  (spi_start),
      .spi_data   (spi_data),
      .spi_busy   (spi_busy),
      .overrun    (overrun),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              r0s;
      logic [DATA_W-1:0] r0d;
      logic              r1s;
      logic [DATA_W-1:0] r1d;
      logic              busy;
      logic              e_start;
      logic [DATA_W-1:0] e_data;
      logic              e_b0;
      logic              e_b1;
      logic              e_d0;
      logic              e_d1;
      logic [1:0]        e_ov;
      logic              e_to;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(int r0s, logic [DATA_W-1:0] r0d, int r1s,
                               logic [DATA_W-1:0] r1d, int busy, int st,
                               logic [DATA_W-1:0] dat, int b0, int b1, int d0, int d1,
                               int ov, int to);
      vec_t v;
      v.r0s     = (r0s != 0);
      v.r0d     = r0d;
      v.r1s     = (r1s != 0);
      v.r1d     = r1d;
      v.busy    = (busy != 0);
      v.e_start = (st != 0);
      v.e_data  = dat;
      v.e_b0    = (b0 != 0);
      v.e_b1    = (b1 != 0);
      v.e_d0    = (d0 != 0);
      v.e_d1    = (d1 != 0);
      v.e_ov    = 2'(ov);
      v.e_to    = (to != 0);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int s0, input logic [DATA_W-1:0] d0,
                        input int s1, input logic [DATA_W-1:0] d1);
      req0_start = (s0 != 0);
      req0_data  = d0;
      req1_start = (s1 != 0);
      req1_data  = d1;
      cyc();
      req0_start = 1'b0;
      req1_start = 1'b0;
   endtask

   // From the IDLE cycle with a word pending: expect START, run a short busy
   // window, then expect the done pulse for requester n.
   task automatic serve(input logic [DATA_W-1:0] d, input int n);
      cyc();
      chk("serve_start", 32'(spi_start), 32'd1);
      chk("serve_data", 32'(spi_data), 32'(d));
      cyc();
      spi_busy = 1'b1;
      cyc();
      spi_busy = 1'b0;
      cyc();
      chk("serve_done", 32'(n == 0 ? req0_done : req1_done), 32'd1);
      chk("serve_other_done", 32'(n == 0 ? req1_done : req0_done), 32'd0);
      chk("serve_gap_nostart", 32'(spi_start), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst        = 1'b0;
      req0_start = 1'b0;
      req0_data  = '0;
      req1_start = 1'b0;
      req1_data  = '0;
      spi_busy   = 1'b0;

      // Request 0x280001 with a 10-cycle busy window; overruns at rows 7 and 10,
      // requester 1 accepted mid-transfer, requester 0 dropped in its done cycle.
      tbl[0] = mk(1, 24'h280001, 0, 24'h0, 0, 0, 24'h000000, 1, 0, 0, 0, 0, 0);
      tbl[1] = mk(0, 24'h0, 0, 24'h0, 0, 1, 24'h280001, 1, 0, 0, 0, 0, 0);
      for (int i = 2; i <= 4; i++) tbl[i] = mk(0, 24'h0, 0, 24'h0, 0, 0, 24'h280001, 1, 0, 0, 0, 0, 0);
      for (int i = 5; i <= 6; i++) tbl[i] = mk(0, 24'h0, 0, 24'h0, 1, 0, 24'h280001, 1, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 24'h123456, 0, 24'h0, 1, 0, 24'h280001, 1, 0, 0, 0, 1, 0);
      tbl[8]  = mk(0, 24'h0, 1, 24'hABCDEF, 1, 0, 24'h280001, 1, 1, 0, 0, 0, 0);
      tbl[9]  = mk(0, 24'h0, 0, 24'h0, 1, 0, 24'h280001, 1, 1, 0, 0, 0, 0);
      tbl[10] = mk(1, 24'h654321, 0, 24'h0, 1, 0, 24'h280001, 1, 1, 0, 0, 1, 0);
      for (int i = 11; i <= 14; i++) tbl[i] = mk(0, 24'h0, 0, 24'h0, 1, 0, 24'h280001, 1, 1, 0, 0, 0, 0);
      tbl[15] = mk(0, 24'h0, 0, 24'h0, 0, 0, 24'h280001, 0, 1, 1, 0, 0, 0);
      tbl[16] = mk(1, 24'h111111, 0, 24'h0, 0, 1, 24'hABCDEF, 0, 1, 0, 0, 1, 0);
      tbl[17] = mk(0, 24'h0, 0, 24'h0, 0, 0, 24'hABCDEF, 0, 1, 0, 0, 0, 0);
      tbl[18] = mk(0, 24'h0, 0, 24'h0, 1, 0, 24'hABCDEF, 0, 1, 0, 0, 0, 0);
      tbl[19] = mk(0, 24'h0, 0, 24'h0, 0, 0, 24'hABCDEF, 0, 0, 0, 1, 0, 0);
      tbl[20] = mk(0, 24'h0, 0, 24'h0, 0, 0, 24'hABCDEF, 0, 0, 0, 0, 0, 0);

      // Asynchronous reset state, before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_spi_start", 32'(spi_start), 32'd0);
      chk("rst_spi_data", 32'(spi_data), 32'd0);
      chk("rst_busy", 32'({req0_busy, req1_busy}), 32'd0);
      chk("rst_done", 32'({req0_done, req1_done}), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      cyc();
      cyc();
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         req0_start = tbl[i].r0s;
         req0_data  = tbl[i].r0d;
         req1_start = tbl[i].r1s;
         req1_data  = tbl[i].r1d;
         spi_busy   = tbl[i].busy;
         cyc();
         chk($sformatf("row%0d_spi_start", i), 32'(spi_start), 32'(tbl[i].e_start));
         chk($sformatf("row%0d_spi_data", i), 32'(spi_data), 32'(tbl[i].e_data));
         chk($sformatf("row%0d_req0_busy", i), 32'(req0_busy), 32'(tbl[i].e_b0));
         chk($sformatf("row%0d_req1_busy", i), 32'(req1_busy), 32'(tbl[i].e_b1));
         chk($sformatf("row%0d_req0_done", i), 32'(req0_done), 32'(tbl[i].e_d0));
         chk($sformatf("row%0d_req1_done", i), 32'(req1_done), 32'(tbl[i].e_d1));
         chk($sformatf("row%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ov));
         chk($sformatf("row%0d_timeout", i), 32'(timeout), 32'(tbl[i].e_to));
      end
      req0_start = 1'b0;
      req1_start = 1'b0;
      spi_busy   = 1'b0;

      // Simultaneous requests: requester 0 first, then 1, and again 0 first.
      pulse(1, 24'h0A0001, 1, 24'h0B0001);
      serve(24'h0A0001, 0);
      serve(24'h0B0001, 1);
      cyc();
      pulse(1, 24'h0A0002, 1, 24'h0B0002);
      serve(24'h0A0002, 0);
      serve(24'h0B0002, 1);
      cyc();

      // Busy never rises: timeout and done 16 cycles after WAIT_BUSY entry.
      pulse(0, 24'h0, 1, 24'h0BEEF1);
      cyc();
      chk("to_spi_start", 32'(spi_start), 32'd1);
      cyc();
      n = 0;
      while (!timeout && n < 40) begin
         chk("to_no_early_done", 32'(req1_done), 32'd0);
         cyc();
         n++;
      end
      chk("to_latency", 32'(n), 32'(TIMEOUT));
      chk("to_req1_done", 32'(req1_done), 32'd1);
      chk("to_req1_busy", 32'(req1_busy), 32'd0);
      cyc();
      chk("to_pulse_once", 32'(timeout), 32'd0);
      pulse(1, 24'h0C0FFE, 0, 24'h0);
      serve(24'h0C0FFE, 0);
      cyc();

      // Reset in WAIT_DONE with requester 1 pending.
      pulse(1, 24'h0A0A0A, 0, 24'h0);
      cyc();
      cyc();
      spi_busy   = 1'b1;
      req1_start = 1'b1;
      req1_data  = 24'h0B0B0B;
      cyc();
      req1_start = 1'b0;
      chk("mr_req1_pending", 32'(req1_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      spi_busy = 1'b0;
      chk("mr_spi_data", 32'(spi_data), 32'd0);
      chk("mr_busy", 32'({req0_busy, req1_busy}), 32'd0);
      chk("mr_start", 32'(spi_start), 32'd0);
      cyc();
      chk("mr_no_done_a", 32'({req0_done, req1_done}), 32'd0);
      cyc();
      chk("mr_no_done_b", 32'({req0_done, req1_done}), 32'd0);
      rst = 1'b0;
      cyc();
      chk("mr_nothing_left", 32'({spi_start, req0_busy, req1_busy}), 32'd0);
      pulse(0, 24'h0, 1, 24'h0D0D0D);
      serve(24'h0D0D0D, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
